cpu_ctrl: RTL and testbench
===========================

CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 SHALL have parameter IP_RESET, default 16'h0000, the IP value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port imem_addr  output  16  instruction address (current IP).
REQ-005 SHALL have port imem_rdata  input  16  instruction word, valid the cycle after imem_addr is presented (synchronous ROM).
REQ-006 SHALL have ports alu_opcode, alu_regA, alu_regB, alu_imm  output  16 each  operands to the ALU: instruction, R[11:9], R[8:6], sign-extended instr[4:0].
REQ-007 SHALL have port alu_res  input  16  ALU result, combinational from the operands.
REQ-008 SHALL have ports alu_n, alu_z, alu_p  input  1 each  ALU condition flags.
REQ-009 SHALL have port instr_done  output  1  one-cycle pulse in WB of every retired instruction.
REQ-010 SHALL have port halt  output  1  high while in HALT state.

Function
REQ-011 SHALL sequence FETCH -> DECODE -> EXEC -> WB -> FETCH, one instruction per 4 cycles; HALT is terminal until rst.
REQ-012 FETCH SHALL drive imem_addr=IP; DECODE SHALL latch imem_rdata into IR and register the alu_* operands, which are held stable through EXEC and WB.
REQ-013 EXEC SHALL register alu_res and alu_n/z/p at the end of the cycle.
REQ-014 Ops 4'h0-4'h9 SHALL write the registered result to R[IR[11:9]] in WB and load nzp from the registered flags.
REQ-015 CMP (4'hA) SHALL update nzp only, with no register write.
REQ-016 LD (4'hB) SHALL write R[IR[11:9]] with R[IR[7:5]] if IR[8]=1, else {8'h00, IR[7:0]}; nzp is unchanged.
REQ-017 BR (4'hC) SHALL set IP=IP+1+sext(IR[8:0]) when (IR[11:9] & nzp)!=0, else IP=IP+1.
REQ-018 JMP (4'hD) SHALL set IP=R[IR[8:6]].
REQ-019 NOP (4'hE) SHALL only advance IP.
REQ-020 HALT (4'hF) SHALL enter HALT after WB without advancing IP; instr_done pulses once.
REQ-021 All other ops SHALL set IP=IP+1 in WB; all IP arithmetic is modulo 2^16 (16'hFFFF+1 -> 16'h0000).
REQ-022 A register written in WB SHALL be visible to the next instruction's DECODE; there is no bypass path.
REQ-023 nzp SHALL be exactly one-hot at all times.

Reset
REQ-024 On rst: state=FETCH, IP=IP_RESET, R0-R7=0, nzp=3'b010, IR=0, alu_* outputs=0, instr_done=0, halt=0.
REQ-025 rst mid-instruction (any state, including HALT) SHALL abort it with no register, nzp or IP side effect beyond the reset values.

Structure
REQ-026 Package cpu_pkg SHALL hold the opcode constants, the state encoding and the IR field positions; the ALU decode shares it.
REQ-027 The register file SHALL be sub-module cpu_regfile: 8x16, two combinational read ports, one synchronous write port, reset to zero.

Verification
REQ-028 Program LD R1,#5; LD R2,#3; ADD R3,R1,R2 -> R3=16'h0008, nzp=p, instr_done pulses every 4 cycles.
REQ-029 SUB R4,R2,R1 with R1=5, R2=3 -> R4=16'hFFFE, nzp=n; then BRn -2 -> IP is taken backward by 2.
REQ-030 CMP R1,R1 -> no register changes, nzp=z; BRp +4 is not taken (IP+1); BRz +4 is taken.
REQ-031 JMP to R=16'hFFFF holding NOP -> next fetch address is 16'h0000.
REQ-032 HALT -> halt=1 and IP frozen for 20 cycles; rst asserted during DECODE of ADD -> destination register unchanged and fetch restarts at IP_RESET.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu controller: widths, state and opcode encodings,
// instruction field positions and small decode helpers.
package cpu_pkg;

  localparam int unsigned XLEN   = 16;
  localparam int unsigned NREG   = 8;
  localparam int unsigned RIDX_W = 3;

  // Instruction field positions
  localparam int unsigned F_OP_HI  = 15;
  localparam int unsigned F_OP_LO  = 12;
  localparam int unsigned F_RD_HI  = 11;
  localparam int unsigned F_RD_LO  = 9;
  localparam int unsigned F_RS_HI  = 8;
  localparam int unsigned F_RS_LO  = 6;
  localparam int unsigned F_LD_SEL = 8;
  localparam int unsigned F_LD_HI  = 7;
  localparam int unsigned F_LD_LO  = 5;
  localparam int unsigned F_IMM_HI = 4;
  localparam int unsigned F_OFF_HI = 8;

  localparam logic [2:0] NZP_RESET = 3'b010;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_NOT  = 4'h5,
    OP_ADDI = 4'h6,
    OP_SHL  = 4'h7,
    OP_SHR  = 4'h8,
    OP_MOVI = 4'h9,
    OP_CMP  = 4'hA,
    OP_LD   = 4'hB,
    OP_BR   = 4'hC,
    OP_JMP  = 4'hD,
    OP_NOP  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  // Ops whose ALU result is written back to the destination register
  function automatic logic op_is_alu(input opcode_e op);
    return op <= OP_MOVI;
  endfunction

  function automatic logic [XLEN-1:0] sext_imm5(input logic [4:0] v);
    return {{(XLEN-5){v[4]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] sext_off9(input logic [8:0] v);
    return {{(XLEN-9){v[8]}}, v};
  endfunction

  // Collapse ALU flags to a one-hot nzp; keep the old value if the flags carry none
  function automatic logic [2:0] flags_to_nzp(input logic [2:0] f, input logic [2:0] keep);
    logic [2:0] r;
    r = keep;
    if (f[2])      r = 3'b100;
    else if (f[1]) r = 3'b010;
    else if (f[0]) r = 3'b001;
    return r;
  endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// Instruction-memory and ALU bus between the controller (master) and its environment.
interface cpu_ctrl_if;
  import cpu_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] alu_opcode;
  logic [XLEN-1:0] alu_regA;
  logic [XLEN-1:0] alu_regB;
  logic [XLEN-1:0] alu_imm;
  logic [XLEN-1:0] alu_res;
  logic            alu_n;
  logic            alu_z;
  logic            alu_p;

  modport master (
    output imem_addr, alu_opcode, alu_regA, alu_regB, alu_imm,
    input  imem_rdata, alu_res, alu_n, alu_z, alu_p
  );

  modport slave (
    input  imem_addr, alu_opcode, alu_regA, alu_regB, alu_imm,
    output imem_rdata, alu_res, alu_n, alu_z, alu_p
  );

endinterface

// File: rtl/cpu_regfile.sv
// 8x16 register file: two combinational read ports, one synchronous write port.
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [RIDX_W-1:0] raddr_a,
  input  logic [RIDX_W-1:0] raddr_b,
  output logic [XLEN-1:0]   rdata_a_c,
  output logic [XLEN-1:0]   rdata_b_c,
  input  logic              we,
  input  logic [RIDX_W-1:0] waddr,
  input  logic [XLEN-1:0]   wdata
);

  logic [XLEN-1:0] regs [NREG];

  // Synchronous write, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a_c = regs[raddr_a];
  assign rdata_b_c = regs[raddr_b];

endmodule

// File: rtl/cpu_ctrl.sv
// Four-cycle multi-cycle controller: FETCH -> DECODE -> EXEC -> WB, with terminal HALT.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter logic [15:0] IP_RESET = 16'h0000
) (
  input  logic       clk,
  input  logic       rst,
  cpu_ctrl_if.master bus,
  output logic       instr_done,
  output logic       halt
);

  state_e            state;
  logic [XLEN-1:0]   ip;
  logic [XLEN-1:0]   ir;
  logic [XLEN-1:0]   res_q;
  logic [2:0]        flags_q;
  logic [2:0]        nzp;
  logic [XLEN-1:0]   opcode_q;
  logic [XLEN-1:0]   reg_a_q;
  logic [XLEN-1:0]   reg_b_q;
  logic [XLEN-1:0]   imm_q;

  opcode_e           op_c;
  logic [RIDX_W-1:0] raddr_a_c;
  logic [RIDX_W-1:0] raddr_b_c;
  logic [RIDX_W-1:0] waddr_c;
  logic [XLEN-1:0]   rdata_a_c;
  logic [XLEN-1:0]   rdata_b_c;
  logic [XLEN-1:0]   wdata_c;
  logic              we_c;
  logic [XLEN-1:0]   ip_next_c;

  assign op_c    = opcode_e'(ir[F_OP_HI:F_OP_LO]);
  assign waddr_c = ir[F_RD_HI:F_RD_LO];

  // Port A reads operand A in DECODE; port B reads operand B in DECODE, LD source afterwards
  always_comb begin
    raddr_a_c = bus.imem_rdata[F_RD_HI:F_RD_LO];
    raddr_b_c = ir[F_LD_HI:F_LD_LO];
    if (state == S_DECODE) raddr_b_c = bus.imem_rdata[F_RS_HI:F_RS_LO];
  end

  // Register writeback in WB: ALU result or LD value
  always_comb begin
    we_c    = 1'b0;
    wdata_c = res_q;
    if (state == S_WB) begin
      if (op_is_alu(op_c)) begin
        we_c = 1'b1;
      end else if (op_c == OP_LD) begin
        we_c    = 1'b1;
        wdata_c = ir[F_LD_SEL] ? rdata_b_c : XLEN'(ir[F_LD_HI:0]);
      end
    end
  end

  // Next instruction pointer, applied in WB; arithmetic wraps at 16 bits
  always_comb begin
    ip_next_c = ip + XLEN'(1);
    case (op_c)
      OP_BR: begin
        if ((ir[F_RD_HI:F_RD_LO] & nzp) != 3'b000)
          ip_next_c = ip + XLEN'(1) + sext_off9(ir[F_OFF_HI:0]);
      end
      OP_JMP:  ip_next_c = reg_b_q;
      OP_HALT: ip_next_c = ip;
      default: ;
    endcase
  end

  cpu_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .raddr_a   (raddr_a_c),
    .raddr_b   (raddr_b_c),
    .rdata_a_c (rdata_a_c),
    .rdata_b_c (rdata_b_c),
    .we        (we_c),
    .waddr     (waddr_c),
    .wdata     (wdata_c)
  );

  // Sequencer and all registered state/outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      ip         <= IP_RESET;
      ir         <= '0;
      res_q      <= '0;
      flags_q    <= '0;
      nzp        <= NZP_RESET;
      opcode_q   <= '0;
      reg_a_q    <= '0;
      reg_b_q    <= '0;
      imm_q      <= '0;
      instr_done <= 1'b0;
      halt       <= 1'b0;
    end else begin
      instr_done <= 1'b0;
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          ir       <= bus.imem_rdata;
          opcode_q <= bus.imem_rdata;
          reg_a_q  <= rdata_a_c;
          reg_b_q  <= rdata_b_c;
          imm_q    <= sext_imm5(bus.imem_rdata[F_IMM_HI:0]);
          state    <= S_EXEC;
        end
        S_EXEC: begin
          res_q      <= bus.alu_res;
          flags_q    <= {bus.alu_n, bus.alu_z, bus.alu_p};
          instr_done <= 1'b1;
          state      <= S_WB;
        end
        S_WB: begin
          if (op_is_alu(op_c) || op_c == OP_CMP) nzp <= flags_to_nzp(flags_q, nzp);
          ip <= ip_next_c;
          if (op_c == OP_HALT) begin
            state <= S_HALT;
            halt  <= 1'b1;
          end else begin
            state <= S_FETCH;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  assign bus.imem_addr  = ip;
  assign bus.alu_opcode = opcode_q;
  assign bus.alu_regA   = reg_a_q;
  assign bus.alu_regB   = reg_b_q;
  assign bus.alu_imm    = imm_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: synchronous ROM + ALU environment, ISA-level reference model,
// a directed program covering branches/wrap/halt/reset, then a random program.
module tb_cpu_ctrl;
  import cpu_pkg::*;

  localparam logic [15:0] IP_RST = 16'h0010;

  logic clk = 1'b0;
  logic rst;
  logic instr_done;
  logic halt;

  cpu_ctrl_if bus ();

  cpu_ctrl #(.IP_RESET(IP_RST)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .instr_done (instr_done),
    .halt       (halt)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [65536];
  int cyc = 0;
  int last_done = -1;
  int n_chk = 0;
  int n_bad = 0;

  // Reference architectural state
  logic [15:0] m_r [8];
  logic [2:0]  m_nzp;
  logic [15:0] m_ip;
  logic        m_halted;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous instruction ROM
  always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

  function automatic logic [15:0] alu_f(input logic [15:0] ins, input logic [15:0] a,
                                        input logic [15:0] b, input logic [15:0] imm);
    logic [15:0] r;
    case (ins[15:12])
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = ~a;
      4'h6: r = a + imm;
      4'h7: r = a << 1;
      4'h8: r = a >> 1;
      4'h9: r = imm;
      4'hA: r = a - b;
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] nzp_of(input logic [15:0] r);
    if (r[15]) return 3'b100;
    if (r == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

  // Combinational ALU seen by the DUT
  always_comb begin
    logic [15:0] r;
    r = alu_f(bus.alu_opcode, bus.alu_regA, bus.alu_regB, bus.alu_imm);
    bus.alu_res = r;
    {bus.alu_n, bus.alu_z, bus.alu_p} = nzp_of(r);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Instruction encoders
  function automatic logic [15:0] e_ldi(input int rd, input int v);
    return {4'hB, 3'(rd), 1'b0, 8'(v)};
  endfunction
  function automatic logic [15:0] e_ldr(input int rd, input int rs);
    return {4'hB, 3'(rd), 1'b1, 3'(rs), 5'd0};
  endfunction
  function automatic logic [15:0] e_alu(input opcode_e op, input int rd, input int rs);
    return {4'(op), 3'(rd), 3'(rs), 6'd0};
  endfunction
  function automatic logic [15:0] e_br(input int cc, input int off);
    return {4'hC, 3'(cc), 9'(off)};
  endfunction
  function automatic logic [15:0] e_jmp(input int rs);
    return {4'hD, 3'd0, 3'(rs), 6'd0};
  endfunction

  // Architectural effect of one instruction
  task automatic model_step(input logic [15:0] ins);
    logic [15:0] a, b, imm, res, off;
    logic [3:0]  op;
    op  = ins[15:12];
    a   = m_r[ins[11:9]];
    b   = m_r[ins[8:6]];
    imm = {{11{ins[4]}}, ins[4:0]};
    off = {{7{ins[8]}}, ins[8:0]};
    if (op <= 4'h9) begin
      res = alu_f(ins, a, b, imm);
      m_r[ins[11:9]] = res;
      m_nzp = nzp_of(res);
      m_ip = m_ip + 16'd1;
    end else begin
      case (op)
        4'hA: begin m_nzp = nzp_of(alu_f(ins, a, b, imm)); m_ip = m_ip + 16'd1; end
        4'hB: begin
          m_r[ins[11:9]] = ins[8] ? m_r[ins[7:5]] : {8'h00, ins[7:0]};
          m_ip = m_ip + 16'd1;
        end
        4'hC: m_ip = ((ins[11:9] & m_nzp) != 3'b000) ? m_ip + 16'd1 + off : m_ip + 16'd1;
        4'hD: m_ip = b;
        4'hF: m_halted = 1'b1;
        default: m_ip = m_ip + 16'd1;
      endcase
    end
  endtask

  // Apply reset from the current negedge and check reset state
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    m_nzp = 3'b010;
    m_ip = IP_RST;
    m_halted = 1'b0;
    last_done = -1;
    check("rst_addr", 32'(bus.imem_addr), 32'(IP_RST));
    check("rst_halt", 32'(halt), 32'(1'b0));
    check("rst_done", 32'(instr_done), 32'(1'b0));
    check("rst_opc", 32'(bus.alu_opcode), 32'(16'h0000));
    check("rst_rega", 32'(bus.alu_regA), 32'(16'h0000));
    check("rst_regb", 32'(bus.alu_regB), 32'(16'h0000));
    check("rst_imm", 32'(bus.alu_imm), 32'(16'h0000));
    check("rst_nzp", 32'(dut.nzp), 32'(m_nzp));
    for (int i = 0; i < 8; i++) check($sformatf("rst_r%0d", i), 32'(dut.u_regfile.regs[i]), 32'(m_r[i]));
    rst = 1'b0;
  endtask

  // Wait for one retirement, advance the model, compare architectural state
  task automatic run_instr(input string tag);
    int n;
    n = 0;
    while (instr_done !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(instr_done), 32'(1'b1));
    if (instr_done !== 1'b1) return;
    check({tag, "_pc"}, 32'(bus.imem_addr), 32'(m_ip));
    if (last_done >= 0) check({tag, "_period"}, 32'(cyc - last_done), 32'd4);
    last_done = cyc;
    model_step(mem[m_ip]);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(instr_done), 32'(1'b0));
    check({tag, "_ip"}, 32'(bus.imem_addr), 32'(m_ip));
    check({tag, "_nzp"}, 32'(dut.nzp), 32'(m_nzp));
    check({tag, "_halt"}, 32'(halt), 32'(m_halted));
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_r%0d", tag, i), 32'(dut.u_regfile.regs[i]), 32'(m_r[i]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 16'hE000;
    mem[16'h0010] = e_ldi(1, 5);
    mem[16'h0011] = e_ldi(2, 3);
    mem[16'h0012] = e_ldr(3, 1);
    mem[16'h0013] = e_alu(OP_ADD, 3, 2);
    mem[16'h0014] = e_ldr(4, 2);
    mem[16'h0015] = e_alu(OP_SUB, 4, 1);
    mem[16'h0016] = e_br(3'b100, 1);
    mem[16'h0018] = e_br(3'b100, -2);
    mem[16'h0017] = e_br(3'b111, 3);
    mem[16'h001B] = e_alu(OP_CMP, 1, 1);
    mem[16'h001C] = e_br(3'b001, 4);
    mem[16'h001D] = e_br(3'b010, 4);
    mem[16'h0022] = e_alu(OP_NOT, 6, 0);
    mem[16'h0023] = e_jmp(6);
    mem[16'hFFFF] = 16'hE000;
    mem[16'h0000] = 16'hF000;
    repeat (3) @(negedge clk);
    do_reset();

    run_instr("ld1");
    run_instr("ld2");
    run_instr("ld3");
    run_instr("add");
    check("add_r3", 32'(dut.u_regfile.regs[3]), 32'(16'h0008));
    check("add_nzp", 32'(dut.nzp), 32'(3'b001));
    run_instr("ld4");
    run_instr("sub");
    check("sub_r4", 32'(dut.u_regfile.regs[4]), 32'(16'hFFFE));
    check("sub_nzp", 32'(dut.nzp), 32'(3'b100));
    run_instr("brn_fwd");
    check("brn_fwd_ip", 32'(bus.imem_addr), 32'(16'h0018));
    run_instr("brn_back");
    check("brn_back_ip", 32'(bus.imem_addr), 32'(16'h0017));
    run_instr("br_all");
    run_instr("cmp");
    check("cmp_nzp", 32'(dut.nzp), 32'(3'b010));
    run_instr("brp");
    check("brp_ip", 32'(bus.imem_addr), 32'(16'h001D));
    run_instr("brz");
    check("brz_ip", 32'(bus.imem_addr), 32'(16'h0022));
    run_instr("not");
    run_instr("jmp");
    check("jmp_ip", 32'(bus.imem_addr), 32'(16'hFFFF));
    run_instr("nop_wrap");
    check("wrap_ip", 32'(bus.imem_addr), 32'(16'h0000));
    run_instr("halt");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt_hold", 32'(halt), 32'(1'b1));
      check("halt_ip", 32'(bus.imem_addr), 32'(16'h0000));
      check("halt_nodone", 32'(instr_done), 32'(1'b0));
    end

    // Reset out of HALT, then abort an ADD during its DECODE
    mem[16'h0010] = e_ldi(7, 9);
    mem[16'h0011] = e_alu(OP_ADD, 7, 7);
    do_reset();
    run_instr("ld7");
    check("ld7_r7", 32'(dut.u_regfile.regs[7]), 32'(16'h0009));
    @(negedge clk);
    check("abort_in_decode", 32'(dut.state), 32'(S_DECODE));
    do_reset();
    check("abort_r7", 32'(dut.u_regfile.regs[7]), 32'(16'h0000));
    check("abort_ip", 32'(bus.imem_addr), 32'(IP_RST));

    // Random program over the whole address space (no HALT)
    for (int i = 0; i < 65536; i++) mem[i] = {4'($urandom_range(14, 0)), 12'($urandom)};
    rst = 1'b1;
    @(negedge clk);
    do_reset();
    for (int k = 0; k < 200; k++) run_instr($sformatf("rnd%0d", k));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
